// File: rtl/fxp_divide.sv
`default_nettype none
// ============================================================================
// Module   : fxp_divide
// Brief    : Fully pipelined signed fixed-point divider (restoring, one
//            quotient bit per stage, saturating output).
// Revision : 1.0 - initial release
// ============================================================================
module fxp_divide #(
  parameter int Q_BITS   = 10,
  parameter int D_WIDTH  = 32,
  parameter int ED_WIDTH = D_WIDTH + Q_BITS + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [D_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  input  logic               valid_in,
  output logic [D_WIDTH-1:0] quotient,
  output logic               valid_out
);

  localparam int                  C_PAD     = ED_WIDTH - D_WIDTH;
  localparam logic [D_WIDTH-1:0]  C_POS_SAT = {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam logic [D_WIDTH-1:0]  C_NEG_SAT = {1'b1, {(D_WIDTH-1){1'b0}}};
  localparam logic [ED_WIDTH-1:0] C_POS_LIM = {{C_PAD{1'b0}}, C_POS_SAT};
  localparam logic [ED_WIDTH-1:0] C_NEG_LIM = {{C_PAD{1'b0}}, C_NEG_SAT};

  // Raw operand capture; the magnitude/sign stage works from these.
  logic [D_WIDTH-1:0] a_q, b_q;
  logic               in_vld_q;

  // Pipeline: index 0 is the input stage, 1..ED_WIDTH the iteration stages.
  logic [ED_WIDTH-1:0] num_q [ED_WIDTH+1];
  logic [ED_WIDTH-1:0] den_q [ED_WIDTH+1];
  logic [ED_WIDTH-1:0] rem_q [ED_WIDTH+1];
  logic [ED_WIDTH-1:0] quo_q [ED_WIDTH+1];
  logic                sgn_q [ED_WIDTH+1];
  logic                dz_q  [ED_WIDTH+1];
  logic                neg_q [ED_WIDTH+1];
  logic                vld_q [ED_WIDTH+1];

  logic [ED_WIDTH-1:0] num_d [ED_WIDTH+1];
  logic [ED_WIDTH-1:0] den_d [ED_WIDTH+1];
  logic [ED_WIDTH-1:0] rem_d [ED_WIDTH+1];
  logic [ED_WIDTH-1:0] quo_d [ED_WIDTH+1];
  logic                sgn_d [ED_WIDTH+1];
  logic                dz_d  [ED_WIDTH+1];
  logic                neg_d [ED_WIDTH+1];
  logic                vld_d [ED_WIDTH+1];

  logic [ED_WIDTH-1:0] ext_a_d, ext_b_d, mag_a_d, mag_b_d;
  logic [ED_WIDTH:0]   trial_d, diff_d;
  logic                ge_d;

  logic [ED_WIDTH-1:0] qmag_d;
  logic [D_WIDTH-1:0]  res_d, quotient_d, quotient_q;
  logic                valid_out_q;

  // Input-stage magnitudes/flags and one restoring-division step per stage.
  always_comb begin
    ext_a_d = {{C_PAD{a_q[D_WIDTH-1]}}, a_q};
    ext_b_d = {{C_PAD{b_q[D_WIDTH-1]}}, b_q};
    // Extended width keeps |-2^(D_WIDTH-1)| exact.
    mag_a_d = a_q[D_WIDTH-1] ? (~ext_a_d + 1'b1) : ext_a_d;
    mag_b_d = b_q[D_WIDTH-1] ? (~ext_b_d + 1'b1) : ext_b_d;

    num_d[0] = mag_a_d << Q_BITS;
    den_d[0] = mag_b_d;
    rem_d[0] = '0;
    quo_d[0] = '0;
    sgn_d[0] = a_q[D_WIDTH-1] ^ b_q[D_WIDTH-1];
    dz_d[0]  = (b_q == '0);
    neg_d[0] = a_q[D_WIDTH-1];
    vld_d[0] = in_vld_q;

    trial_d = '0;
    diff_d  = '0;
    ge_d    = 1'b0;
    for (int s = 1; s <= ED_WIDTH; s++) begin
      // Bring down the next numerator bit, MSB first.
      trial_d  = {rem_q[s-1], num_q[s-1][ED_WIDTH-s]};
      diff_d   = trial_d - {1'b0, den_q[s-1]};
      ge_d     = (trial_d >= {1'b0, den_q[s-1]});
      rem_d[s] = ge_d ? diff_d[ED_WIDTH-1:0] : trial_d[ED_WIDTH-1:0];
      quo_d[s] = {quo_q[s-1][ED_WIDTH-2:0], ge_d};
      num_d[s] = num_q[s-1];
      den_d[s] = den_q[s-1];
      sgn_d[s] = sgn_q[s-1];
      dz_d[s]  = dz_q[s-1];
      neg_d[s] = neg_q[s-1];
      vld_d[s] = vld_q[s-1];
    end
  end

  // Output stage: saturate on divide-by-zero or range overflow, else apply sign.
  always_comb begin
    qmag_d = quo_q[ED_WIDTH];
    if (dz_q[ED_WIDTH]) begin
      res_d = neg_q[ED_WIDTH] ? C_NEG_SAT : C_POS_SAT;
    end else if (!sgn_q[ED_WIDTH] && (qmag_d > C_POS_LIM)) begin
      res_d = C_POS_SAT;
    end else if (sgn_q[ED_WIDTH] && (qmag_d > C_NEG_LIM)) begin
      res_d = C_NEG_SAT;
    end else if (sgn_q[ED_WIDTH]) begin
      // Negating zero yields zero, so a zero magnitude stays +0.
      res_d = ~qmag_d[D_WIDTH-1:0] + 1'b1;
    end else begin
      res_d = qmag_d[D_WIDTH-1:0];
    end
    quotient_d = vld_q[ED_WIDTH] ? res_d : quotient_q;
  end

  // All pipeline registers; everything clears on reset so in-flight work is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q         <= '0;
      b_q         <= '0;
      in_vld_q    <= 1'b0;
      quotient_q  <= '0;
      valid_out_q <= 1'b0;
      for (int s = 0; s <= ED_WIDTH; s++) begin
        num_q[s] <= '0;
        den_q[s] <= '0;
        rem_q[s] <= '0;
        quo_q[s] <= '0;
        sgn_q[s] <= 1'b0;
        dz_q[s]  <= 1'b0;
        neg_q[s] <= 1'b0;
        vld_q[s] <= 1'b0;
      end
    end else begin
      a_q         <= dividend;
      b_q         <= divisor;
      in_vld_q    <= valid_in;
      quotient_q  <= quotient_d;
      valid_out_q <= vld_q[ED_WIDTH];
      for (int s = 0; s <= ED_WIDTH; s++) begin
        num_q[s] <= num_d[s];
        den_q[s] <= den_d[s];
        rem_q[s] <= rem_d[s];
        quo_q[s] <= quo_d[s];
        sgn_q[s] <= sgn_d[s];
        dz_q[s]  <= dz_d[s];
        neg_q[s] <= neg_d[s];
        vld_q[s] <= vld_d[s];
      end
    end
  end

  assign quotient  = quotient_q;
  assign valid_out = valid_out_q;

endmodule
`default_nettype wire

// File: tb/tb_fxp_divide.sv
`default_nettype none
// ============================================================================
// Module   : tb_fxp_divide
// Brief    : Self-checking bench for fxp_divide with an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fxp_divide;

  localparam int C_LAT = 45;

  logic        clock;
  logic        reset;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        valid_in;
  logic [31:0] quotient;
  logic        valid_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  fxp_divide divide (
    .clock     (clock),
    .reset     (reset),
    .dividend  (dividend),
    .divisor   (divisor),
    .valid_in  (valid_in),
    .quotient  (quotient),
    .valid_out (valid_out)
  );

  always #5 clock = ~clock;

  // Edge counter used to measure latency.
  always @(posedge clock) cyc <= cyc + 1;

  // Reference: quotient = trunc(a*2^10/b), saturated to 32-bit signed.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint na, nb, q;
    longint c_max, c_min;
    c_max = 64'sd2147483647;
    c_min = -64'sd2147483648;
    na = longint'($signed(a));
    nb = longint'($signed(b));
    if (nb == 0) return (na < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    q = (na * 1024) / nb;
    if (q > c_max) return 32'h7FFF_FFFF;
    if (q < c_min) return 32'h8000_0000;
    return q[31:0];
  endfunction

  // Issue one operation and observe its result; no judgement made here.
  task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b,
                                output bit found, output int lat,
                                output logic [31:0] q, output logic [31:0] q_hold,
                                output bit extra);
    int acc;
    found = 0; lat = -1; q = '0;
    dividend = a; divisor = b; valid_in = 1'b1;
    @(posedge clock); #1;
    acc = cyc;
    valid_in = 1'b0; dividend = $urandom; divisor = $urandom;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clock); #1;
      if (valid_out) begin
        found = 1; q = quotient; lat = cyc - acc;
      end
    end
    @(posedge clock); #1;
    extra = valid_out; q_hold = quotient;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++;
    if (quotient !== 32'h0) begin errors++; $display("FAIL reset_quotient: got %h expected 00000000", quotient); end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [7], tb [7], te [7];
    bit found, extra; int lat; logic [31:0] q, qh;
    ta[0] = -32'sd194560;  tb[0] = 32'd7168;       te[0] = 32'hFFFF_936E;
    ta[1] = 32'd1024;      tb[1] = 32'd2048;       te[1] = 32'd512;
    ta[2] = 32'd7168;      tb[2] = -32'sd2048;     te[2] = -32'sd3584;
    ta[3] = -32'sd3072;    tb[3] = -32'sd1536;     te[3] = 32'd2048;
    ta[4] = 32'd0;         tb[4] = 32'd3000;       te[4] = 32'd0;
    ta[5] = -32'sd1;       tb[5] = 32'd5000;       te[5] = 32'd0;
    ta[6] = 32'd1;         tb[6] = 32'd1;          te[6] = 32'd1024;
    for (int i = 0; i < 7; i++) begin
      issue_and_wait(ta[i], tb[i], found, lat, q, qh, extra);
      checks++;
      if (!found) begin errors++; $display("FAIL directed%0d_seen: got no valid_out expected one", i); end
      checks++;
      if (lat != C_LAT) begin errors++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, C_LAT); end
      checks++;
      if (q !== te[i]) begin errors++; $display("FAIL directed%0d_value: got %h expected %h", i, q, te[i]); end
      checks++;
      if (extra !== 1'b0) begin errors++; $display("FAIL directed%0d_pulse: got valid_out %b expected 0", i, extra); end
      checks++;
      if (qh !== te[i]) begin errors++; $display("FAIL directed%0d_hold: got %h expected %h", i, qh, te[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] ta [6], tb [6], te [6];
    bit found, extra; int lat; logic [31:0] q, qh;
    ta[0] = 32'd5120;      tb[0] = 32'd0;          te[0] = 32'h7FFF_FFFF;
    ta[1] = -32'sd5120;    tb[1] = 32'd0;          te[1] = 32'h8000_0000;
    ta[2] = 32'd0;         tb[2] = 32'd0;          te[2] = 32'h7FFF_FFFF;
    ta[3] = 32'h7FFF_FFFF; tb[3] = 32'd1;          te[3] = 32'h7FFF_FFFF;
    ta[4] = 32'h8000_0000; tb[4] = 32'd1;          te[4] = 32'h8000_0000;
    ta[5] = 32'h8000_0000; tb[5] = -32'sd1024;     te[5] = 32'h7FFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      issue_and_wait(ta[i], tb[i], found, lat, q, qh, extra);
      checks++;
      if (!found) begin errors++; $display("FAIL sat%0d_seen: got no valid_out expected one", i); end
      checks++;
      if (lat != C_LAT) begin errors++; $display("FAIL sat%0d_latency: got %0d expected %0d", i, lat, C_LAT); end
      checks++;
      if (q !== te[i]) begin errors++; $display("FAIL sat%0d_value: got %h expected %h", i, q, te[i]); end
      checks++;
      if (extra !== 1'b0) begin errors++; $display("FAIL sat%0d_pulse: got valid_out %b expected 0", i, extra); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    int          acc_q [$];
    int          sent, got, acc;
    bit          v;
    logic [31:0] a, b, e;
    sent = 0; got = 0;
    fork
      begin
        while (sent < 50) begin
          v = ($urandom_range(0, 3) != 0);
          a = $urandom >> $urandom_range(0, 24);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 19) == 0) a = 32'h8000_0000;
          b = $urandom >> $urandom_range(4, 31);
          if ($urandom_range(0, 1) == 1) b = -b;
          if ($urandom_range(0, 15) == 0) b = 32'd0;
          dividend = a; divisor = b; valid_in = v;
          @(posedge clock); #1;
          if (v) begin
            exp_q.push_back(ref_div(a, b));
            acc_q.push_back(cyc);
            sent++;
          end
        end
        valid_in = 1'b0;
      end
      begin
        for (int i = 0; i < 400 && got < 50; i++) begin
          @(posedge clock); #1;
          if (valid_out) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL stream_unexpected: got valid_out with quotient %h expected none", quotient);
            end else begin
              e = exp_q.pop_front();
              acc = acc_q.pop_front();
              if (quotient !== e) begin errors++; $display("FAIL stream%0d_value: got %h expected %h", got, quotient, e); end
              checks++;
              if (cyc - acc != C_LAT) begin errors++; $display("FAIL stream%0d_latency: got %0d expected %0d", got, cyc - acc, C_LAT); end
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 50) begin errors++; $display("FAIL stream_count: got %0d results expected 50", got); end
    repeat (5) @(posedge clock);
    #1;
  endtask

  task automatic test_reset_midflight();
    bit found, extra; int lat; logic [31:0] q, qh;
    int bad;
    for (int i = 0; i < 10; i++) begin
      dividend = ($urandom >> 8) + 32'd1; divisor = ($urandom >> 12) + 32'd1; valid_in = 1'b1;
      @(posedge clock); #1;
    end
    valid_in = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", valid_out); end
    checks++;
    if (quotient !== 32'h0) begin errors++; $display("FAIL midreset_quotient: got %h expected 00000000", quotient); end
    bad = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (valid_out !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midreset_hold: got %0d valid cycles expected 0", bad); end
    // Release and issue immediately: the next edge must accept it, and any
    // earlier valid_out would be a stale result showing a short latency.
    reset = 1'b1;
    issue_and_wait(32'd1024, 32'd2048, found, lat, q, qh, extra);
    checks++;
    if (!found) begin errors++; $display("FAIL postreset_seen: got no valid_out expected one"); end
    checks++;
    if (lat != C_LAT) begin errors++; $display("FAIL postreset_latency: got %0d expected %0d", lat, C_LAT); end
    checks++;
    if (q !== 32'd512) begin errors++; $display("FAIL postreset_value: got %h expected %h", q, 32'd512); end
    checks++;
    if (extra !== 1'b0) begin errors++; $display("FAIL postreset_pulse: got valid_out %b expected 0", extra); end
  endtask

  initial begin
    clock    = 1'b0;
    reset    = 1'b0;
    valid_in = 1'b0;
    dividend = '0;
    divisor  = '0;
    test_reset();
    test_directed();
    test_saturation();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
